// File: rtl/execute_stage.sv
// Execute stage: ALU ops, branch resolve, 32-iteration shift-add MUL, HLT latch.
// Latency: 1 cycle for single-cycle ops; MUL result MUL_CYCLES cycles after its accept edge.
// Backpressure: stall is high during MUL; ID_EX is ignored while BUSY or HALTED.
//
// Ports: clock/reset_n (sync active-low), ID_EX decode bundle in,
// EX_MEM registered writeback bundle out, branch_taken/branch_target redirect,
// stall (MUL busy), halted (sticky), illegal (non-one-hot op pulse).
module execute_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [175:0] ID_EX,
  output logic [71:0]  EX_MEM,
  output logic         branch_taken,
  output logic [31:0]  branch_target,
  output logic         stall,
  output logic         halted,
  output logic         illegal
);

  typedef struct packed {
    logic [15:0] op;
    logic [31:0] imm;
    logic [31:0] rt;
    logic [31:0] rs;
    logic [31:0] pc;
    logic [31:0] instr;
  } id_ex_t;

  typedef struct packed {
    logic        halt;
    logic        valid;
    logic        wr_en;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] result;
  } ex_mem_t;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_HALTED} state_t;

  localparam int CNT_W = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  localparam logic [15:0] OP_ADD = 16'h0001, OP_SUB = 16'h0002, OP_LI  = 16'h0004,
                          OP_SHL = 16'h0008, OP_SHR = 16'h0010, OP_AND = 16'h0020,
                          OP_OR  = 16'h0040, OP_XOR = 16'h0080, OP_BR  = 16'h0100,
                          OP_BNE = 16'h0200, OP_MOV = 16'h0400, OP_ADI = 16'h0800,
                          OP_MUL = 16'h1000, OP_HLT = 16'h2000, OP_NOP = 16'h4000;

  id_ex_t id;
  assign id = ID_EX;

  logic [4:0] rd_idx, rt_idx, shamt;
  assign rd_idx = id.instr[15:11];
  assign rt_idx = id.instr[20:16];
  assign shamt  = id.instr[10:6];

  logic unused_instr;
  assign unused_instr = ^{id.instr[31:21], id.instr[5:0]};

  state_t         state_q, state_d;
  ex_mem_t        ex_q, ex_d;
  logic           br_q, br_d;
  logic [31:0]    tgt_q, tgt_d;
  logic           stall_q, stall_d;
  logic           halted_q, halted_d;
  logic           illegal_q, illegal_d;
  logic [31:0]    mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, mpc_q, mpc_d;
  logic [4:0]     mrd_q, mrd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]    acc_sum;

  // One multiplier bit per BUSY edge; the multiplicand shifts up as the multiplier shifts down.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : 32'h0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ex_q      <= '0;
      br_q      <= 1'b0;
      tgt_q     <= '0;
      stall_q   <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      mpc_q     <= '0;
      mrd_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ex_q      <= ex_d;
      br_q      <= br_d;
      tgt_q     <= tgt_d;
      stall_q   <= stall_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      mpc_q     <= mpc_d;
      mrd_q     <= mrd_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (id.op == OP_MUL)      state_d = ST_BUSY;
        else if (id.op == OP_HLT) state_d = ST_HALTED;
      end
      ST_BUSY:   if (cnt_q == CNT_LAST) state_d = ST_IDLE;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    // Pulse-type outputs default low so nothing is held beyond one cycle.
    ex_d      = '0;
    br_d      = 1'b0;
    tgt_d     = '0;
    stall_d   = 1'b0;
    halted_d  = halted_q;
    illegal_d = 1'b0;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    mpc_d     = mpc_q;
    mrd_d     = mrd_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        ex_d.pc    = id.pc;
        ex_d.valid = 1'b1;
        ex_d.wr_en = 1'b1;
        ex_d.dest  = rd_idx;
        case (id.op)
          OP_ADD: ex_d.result = id.rs + id.rt;
          OP_SUB: ex_d.result = id.rs - id.rt;
          OP_LI: begin
            ex_d.result = id.imm;
            ex_d.dest   = rt_idx;
          end
          OP_SHL: ex_d.result = id.rt << shamt;
          OP_SHR: ex_d.result = id.rt >> shamt;
          OP_AND: ex_d.result = id.rs & id.rt;
          OP_OR:  ex_d.result = id.rs | id.rt;
          OP_XOR: ex_d.result = id.rs ^ id.rt;
          OP_MOV: ex_d.result = id.rs;
          OP_ADI: begin
            ex_d.result = id.rs + id.imm;
            ex_d.dest   = rt_idx;
          end
          OP_BR, OP_BNE: begin
            ex_d.wr_en = 1'b0;
            ex_d.dest  = '0;
            br_d       = (id.op == OP_BR) || (id.rs != id.rt);
            if (br_d) tgt_d = id.pc + 32'd4 + (id.imm << 2);
          end
          OP_MUL: begin
            ex_d     = '0;
            stall_d  = 1'b1;
            mcand_d  = id.rs;
            mplier_d = id.rt;
            acc_d    = '0;
            cnt_d    = '0;
            mpc_d    = id.pc;
            mrd_d    = rd_idx;
          end
          OP_HLT: begin
            ex_d.halt  = 1'b1;
            ex_d.wr_en = 1'b0;
            ex_d.dest  = '0;
            halted_d   = 1'b1;
          end
          16'h0000, OP_NOP: ex_d = '0;
          // Anything else has zero or several op bits outside the legal set.
          default: begin
            ex_d      = '0;
            illegal_d = 1'b1;
          end
        endcase
      end

      ST_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          ex_d.valid  = 1'b1;
          ex_d.wr_en  = 1'b1;
          ex_d.dest   = mrd_q;
          ex_d.pc     = mpc_q;
          ex_d.result = acc_sum;
        end else begin
          stall_d = 1'b1;
        end
      end

      default: ;  // HALTED: inputs ignored, all pulses stay low
    endcase
  end

  assign EX_MEM        = ex_q;
  assign branch_taken  = br_q;
  assign branch_target = tgt_q;
  assign stall         = stall_q;
  assign halted        = halted_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios plus randomized ops against a reference model.
// Latency: checks sample 1 time unit after each posedge.
// Backpressure: bench holds ID_EX while stall is high.
module tb_execute_stage;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [175:0] ID_EX = '0;
  logic [71:0]  EX_MEM;
  logic         branch_taken;
  logic [31:0]  branch_target;
  logic         stall;
  logic         halted;
  logic         illegal;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [15:0] OP_ADD = 16'h0001, OP_SUB = 16'h0002, OP_LI  = 16'h0004,
                          OP_SHL = 16'h0008, OP_SHR = 16'h0010, OP_AND = 16'h0020,
                          OP_OR  = 16'h0040, OP_XOR = 16'h0080, OP_BR  = 16'h0100,
                          OP_BNE = 16'h0200, OP_MOV = 16'h0400, OP_ADI = 16'h0800,
                          OP_MUL = 16'h1000, OP_HLT = 16'h2000, OP_NOP = 16'h4000;

  execute_stage #(.MUL_CYCLES(32)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ID_EX         (ID_EX),
    .EX_MEM        (EX_MEM),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .halted        (halted),
    .illegal       (illegal)
  );

  always #5 clock = ~clock;

  function automatic logic [175:0] mk(input logic [15:0] op, input logic [31:0] pc,
                                      input logic [31:0] rs, input logic [31:0] rt,
                                      input logic [31:0] imm, input logic [4:0] rd,
                                      input logic [4:0] rti, input logic [4:0] sh);
    logic [31:0] instr;
    instr = {11'h0, rti, rd, sh, 6'h0};
    return {op, imm, rt, rs, pc, instr};
  endfunction

  function automatic logic [71:0] em(input logic halt, input logic valid, input logic wr,
                                     input logic [4:0] dest, input logic [31:0] pc,
                                     input logic [31:0] result);
    return {halt, valid, wr, dest, pc, result};
  endfunction

  // Reference behaviour of one instruction accepted in IDLE (MUL/HLT handled in their own tests).
  function automatic void ref_exec(input logic [15:0] op, input logic [31:0] pc,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [31:0] imm, input logic [4:0] rd,
                                   input logic [4:0] rti, input logic [4:0] sh,
                                   output logic [71:0] e, output logic br,
                                   output logic [31:0] tgt, output logic ill);
    e = '0; br = 1'b0; tgt = '0; ill = 1'b0;
    if (op == 16'h0 || op == OP_NOP) return;
    if ($countones(op) != 1 || op[15]) begin
      ill = 1'b1;
      return;
    end
    case (op)
      OP_ADD: e = em(0, 1, 1, rd, pc, rs + rt);
      OP_SUB: e = em(0, 1, 1, rd, pc, rs - rt);
      OP_LI:  e = em(0, 1, 1, rti, pc, imm);
      OP_SHL: e = em(0, 1, 1, rd, pc, rt << sh);
      OP_SHR: e = em(0, 1, 1, rd, pc, rt >> sh);
      OP_AND: e = em(0, 1, 1, rd, pc, rs & rt);
      OP_OR:  e = em(0, 1, 1, rd, pc, rs | rt);
      OP_XOR: e = em(0, 1, 1, rd, pc, rs ^ rt);
      OP_MOV: e = em(0, 1, 1, rd, pc, rs);
      OP_ADI: e = em(0, 1, 1, rti, pc, rs + imm);
      OP_BR, OP_BNE: begin
        e   = em(0, 1, 0, 5'd0, pc, 32'd0);
        br  = (op == OP_BR) || (rs != rt);
        tgt = pc + 32'd4 + imm * 32'd4;
      end
      default: e = '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ID_EX   = mk(OP_ADD, 32'h40, 32'd1, 32'd2, 32'd0, 5'd1, 5'd0, 5'd0);
    tick();
    tick();
    n_checks++;
    if ({EX_MEM, branch_taken, branch_target, stall, halted, illegal} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ex_mem=%h br=%b tgt=%h stall=%b halted=%b ill=%b, want all 0",
               EX_MEM, branch_taken, branch_target, stall, halted, illegal);
    end
    reset_n = 1'b1;
    ID_EX   = mk(OP_NOP, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_directed_alu();
    logic [71:0] want;
    ID_EX = mk(OP_ADD, 32'h10, 32'd5, 32'd7, 32'd0, 5'd3, 5'd0, 5'd0);
    tick();
    want = em(0, 1, 1, 5'd3, 32'h10, 32'd12);
    n_checks++;
    if (EX_MEM !== want) begin n_fail++; $display("FAIL add_5_7: got %h want %h", EX_MEM, want); end

    ID_EX = mk(OP_ADD, 32'h14, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd2, 5'd0, 5'd0);
    tick();
    want = em(0, 1, 1, 5'd2, 32'h14, 32'd0);
    n_checks++;
    if (EX_MEM !== want) begin n_fail++; $display("FAIL add_wrap: got %h want %h", EX_MEM, want); end

    ID_EX = mk(OP_SHL, 32'h18, 32'd0, 32'h000000F1, 32'd0, 5'd5, 5'd0, 5'd4);
    tick();
    want = em(0, 1, 1, 5'd5, 32'h18, 32'h00000F10);
    n_checks++;
    if (EX_MEM !== want) begin n_fail++; $display("FAIL shl_4: got %h want %h", EX_MEM, want); end

    ID_EX = mk(OP_SHR, 32'h1C, 32'd0, 32'h80000000, 32'd0, 5'd6, 5'd0, 5'd31);
    tick();
    want = em(0, 1, 1, 5'd6, 32'h1C, 32'h00000001);
    n_checks++;
    if (EX_MEM !== want) begin n_fail++; $display("FAIL shr_31: got %h want %h", EX_MEM, want); end

    ID_EX = mk(OP_LI, 32'h20, 32'd0, 32'd0, 32'hFFFF8000, 5'd1, 5'd9, 5'd0);
    tick();
    want = em(0, 1, 1, 5'd9, 32'h20, 32'hFFFF8000);
    n_checks++;
    if (EX_MEM !== want) begin n_fail++; $display("FAIL li_rt9: got %h want %h", EX_MEM, want); end
  endtask

  task automatic test_branch();
    ID_EX = mk(OP_BNE, 32'h100, 32'd1, 32'd2, 32'hFFFFFFFE, 5'd0, 5'd0, 5'd0);
    tick();
    n_checks++;
    if (branch_taken !== 1'b1 || branch_target !== 32'hFC) begin
      n_fail++;
      $display("FAIL bne_taken: br=%b tgt=%h want 1 000000fc", branch_taken, branch_target);
    end
    ID_EX = mk(OP_BNE, 32'h100, 32'd2, 32'd2, 32'hFFFFFFFE, 5'd0, 5'd0, 5'd0);
    tick();
    n_checks++;
    if (branch_taken !== 1'b0 || EX_MEM[70] !== 1'b1 || EX_MEM[69] !== 1'b0) begin
      n_fail++;
      $display("FAIL bne_not_taken: br=%b valid=%b wr=%b want 0 1 0",
               branch_taken, EX_MEM[70], EX_MEM[69]);
    end
  endtask

  task automatic test_random_ops();
    logic [15:0] ops [14] = '{OP_ADD, OP_SUB, OP_LI, OP_SHL, OP_SHR, OP_AND, OP_OR,
                              OP_XOR, OP_MOV, OP_ADI, OP_BR, OP_BNE, OP_NOP, 16'h0};
    for (int i = 0; i < 80; i++) begin
      logic [15:0] op;
      logic [31:0] pc, rs, rt, imm, tgt;
      logic [4:0]  rd, rti, sh;
      logic [71:0] e;
      logic        br, ill;
      int          pick, a, b;
      pick = int'($urandom_range(0, 16));
      if (pick < 14) op = ops[pick];
      else if (pick == 14) op = 16'h8000;
      else begin
        a  = int'($urandom_range(0, 15));
        b  = (a + int'($urandom_range(1, 15))) % 16;
        op = (16'h1 << a) | (16'h1 << b);
      end
      pc  = $urandom; rs = $urandom; imm = $urandom;
      rt  = ($urandom_range(0, 1) == 1) ? rs : $urandom;
      rd  = 5'($urandom); rti = 5'($urandom); sh = 5'($urandom);
      ref_exec(op, pc, rs, rt, imm, rd, rti, sh, e, br, tgt, ill);
      ID_EX = mk(op, pc, rs, rt, imm, rd, rti, sh);
      tick();
      n_checks++;
      if (EX_MEM !== e || branch_taken !== br || illegal !== ill || stall !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_op[%0d] op=%h: ex_mem=%h br=%b ill=%b stall=%b want %h %b %b 0",
                 i, op, EX_MEM, branch_taken, illegal, stall, e, br, ill);
      end
      if (br) begin
        n_checks++;
        if (branch_target !== tgt) begin
          n_fail++;
          $display("FAIL rand_target[%0d]: got %h want %h", i, branch_target, tgt);
        end
      end
    end
    ID_EX = mk(OP_NOP, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_mul();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] rs, rt, pc;
      logic [4:0]  rd;
      logic [71:0] want;
      int          stall_cycles;
      bit          valid_seen;
      if (k == 0) begin rs = 32'hFFFFFFFF; rt = 32'd3; rd = 5'd4; pc = 32'h200; end
      else begin rs = $urandom; rt = $urandom; rd = 5'($urandom); pc = $urandom; end
      ID_EX = mk(OP_MUL, pc, rs, rt, 32'd0, rd, 5'd0, 5'd0);
      tick();
      // Upstream now presents the next instruction and holds it while stall is high.
      ID_EX = mk(OP_ADD, pc + 32'd4, 32'd10, 32'd20, 32'd0, 5'd7, 5'd0, 5'd0);
      stall_cycles = 0;
      valid_seen   = 1'b0;
      while (stall === 1'b1 && stall_cycles < 100) begin
        stall_cycles++;
        if (EX_MEM[70] !== 1'b0) valid_seen = 1'b1;
        tick();
      end
      n_checks++;
      if (stall_cycles != 32 || valid_seen) begin
        n_fail++;
        $display("FAIL mul_stall[%0d]: stall_cycles=%0d valid_during_busy=%b want 32 0",
                 k, stall_cycles, valid_seen);
      end
      want = em(0, 1, 1, rd, pc, rs * rt);
      n_checks++;
      if (EX_MEM !== want) begin
        n_fail++;
        $display("FAIL mul_result[%0d]: got %h want %h", k, EX_MEM, want);
      end
      tick();
      want = em(0, 1, 1, 5'd7, pc + 32'd4, 32'd30);
      n_checks++;
      if (EX_MEM !== want || stall !== 1'b0) begin
        n_fail++;
        $display("FAIL mul_then_add[%0d]: got %h stall=%b want %h 0", k, EX_MEM, stall, want);
      end
      ID_EX = mk(OP_NOP, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic test_mul_reset();
    logic [71:0] want;
    bit          valid_seen;
    ID_EX = mk(OP_MUL, 32'h400, 32'd9, 32'd9, 32'd0, 5'd8, 5'd0, 5'd0);
    tick();
    ID_EX = mk(OP_NOP, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) tick();
    reset_n = 1'b0;
    tick();
    n_checks++;
    if ({EX_MEM, branch_taken, branch_target, stall, halted, illegal} !== '0) begin
      n_fail++;
      $display("FAIL mul_reset_outputs: ex_mem=%h stall=%b br=%b, want all 0",
               EX_MEM, stall, branch_taken);
    end
    reset_n = 1'b1;
    ID_EX   = mk(OP_ADD, 32'h500, 32'd3, 32'd4, 32'd0, 5'd2, 5'd0, 5'd0);
    tick();
    want = em(0, 1, 1, 5'd2, 32'h500, 32'd7);
    n_checks++;
    if (EX_MEM !== want) begin
      n_fail++;
      $display("FAIL add_after_mul_reset: got %h want %h", EX_MEM, want);
    end
    ID_EX      = mk(OP_NOP, 0, 0, 0, 0, 0, 0, 0);
    valid_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (EX_MEM[70] !== 1'b0 || stall !== 1'b0) valid_seen = 1'b1;
    end
    n_checks++;
    if (valid_seen) begin
      n_fail++;
      $display("FAIL mul_reset_no_result: stray valid/stall seen=1 want 0");
    end
  endtask

  task automatic test_halt();
    logic [71:0] want;
    bit          leak;
    ID_EX = mk(OP_HLT, 32'h300, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    tick();
    want = em(1, 1, 0, 5'd0, 32'h300, 32'd0);
    n_checks++;
    if (EX_MEM !== want || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL hlt_emit: got %h halted=%b want %h 1", EX_MEM, halted, want);
    end
    leak = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ID_EX = (i % 2 == 0) ? mk(OP_ADD, 32'h304, 32'd1, 32'd1, 32'd0, 5'd1, 5'd0, 5'd0)
                           : mk(OP_BR, 32'h308, 32'd0, 32'd0, 32'd4, 5'd0, 5'd0, 5'd0);
      tick();
      if (EX_MEM[70] !== 1'b0 || branch_taken !== 1'b0 || halted !== 1'b1) leak = 1'b1;
    end
    n_checks++;
    if (leak) begin
      n_fail++;
      $display("FAIL halted_ignores_input: activity while halted=1 want none");
    end
    reset_n = 1'b0;
    tick();
    n_checks++;
    if (halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_cleared_by_reset: halted=%b want 0", halted);
    end
    reset_n = 1'b1;
    ID_EX   = mk(OP_SUB, 32'h600, 32'd3, 32'd5, 32'd0, 5'd11, 5'd0, 5'd0);
    tick();
    want = em(0, 1, 1, 5'd11, 32'h600, 32'hFFFFFFFE);
    n_checks++;
    if (EX_MEM !== want) begin
      n_fail++;
      $display("FAIL sub_after_halt_reset: got %h want %h", EX_MEM, want);
    end
  endtask

  task automatic test_illegal();
    ID_EX = mk(16'h0003, 32'h700, 32'd1, 32'd2, 32'd0, 5'd1, 5'd0, 5'd0);
    tick();
    n_checks++;
    if (illegal !== 1'b1 || EX_MEM !== '0) begin
      n_fail++;
      $display("FAIL illegal_0003: ill=%b ex_mem=%h want 1 0", illegal, EX_MEM);
    end
    ID_EX = mk(OP_NOP, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_checks++;
    if (illegal !== 1'b0 || EX_MEM !== '0) begin
      n_fail++;
      $display("FAIL illegal_pulse_end: ill=%b ex_mem=%h want 0 0", illegal, EX_MEM);
    end
  endtask

  initial begin
    test_reset();
    test_directed_alu();
    test_branch();
    test_random_ops();
    test_mul();
    test_mul_reset();
    test_illegal();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
